jogador_ctrl: RTL
=================

Name: jogador_ctrl

Overview:
- Parametrised light-cycle player controller. Supersedes the single fixed player block; one instance is used per player.
- Each instance keeps the player's position and heading, and advances one cell per movement tick.
- On each move it checks the arena bounds, then reads the shared trail RAM at the target cell. It writes its own trail code at the cell it leaves.
- It drives a pixel-hit flag for the VGA compositor and a latched game_over flag.

Parameters:
- START_X, 216: initial x of the player's top-left pixel.
- START_Y, 240: initial y of the player's top-left pixel.
- START_DIR, 0: initial heading; 0=right, 1=down, 2=left, 3=up.
- CELL, 8: player square size and step size, in pixels.
- TICK_PERIOD, 1000000: VGA_CLK cycles per movement tick.
- X_MIN, 16 / X_MAX, 623 / Y_MIN, 16 / Y_MAX, 463: inclusive playable bounds for the top-left pixel.
- SCREEN_W, 640: row stride for RAM addressing.
- ADDR_W, 19: RAM address width.
- TRAIL_CODE, 8'hFF: 8-bit value written to mark this player's trail. It must be nonzero.

Ports:
- VGA_CLK  in  1  sole clock.
- reset  in  1  synchronous, active-high; full initialisation.
- reiniciar  in  1  synchronous restart. Same effect as reset on the position, heading, tick and game state.
- turn_ccw_n  in  1  active-low counter-clockwise key.
- turn_cw_n  in  1  active-low clockwise key.
- next_x  in  10  x of the pixel being drawn.
- next_y  in  10  y of the pixel being drawn.
- pixel_hit  out  1  pixel (next_x, next_y) lies inside the player square.
- ram_addr  out  ADDR_W  trail RAM address.
- ram_wren  out  1  trail RAM write strobe.
- ram_wdata  out  8  trail RAM write data.
- ram_rdata  in  8  trail RAM read data, valid one cycle after ram_addr is presented.
- game_over  out  1  set when the player crashes; holds until restarted.
- dir  out  2  current heading.
- pos_x  out  10  current x.
- pos_y  out  10  current y.

Behaviour:
- All state changes on posedge VGA_CLK. Reset is synchronous, active-high.
- Reset and reiniciar give: pos=(START_X, START_Y), dir=START_DIR, tick counter=0, FSM=RUN, key FSM=IDLE, pending turn cleared, game_over=0, ram_wren=0, ram_addr=0, ram_wdata=TRAIL_CODE.
- reset has priority over reiniciar, which has priority over all other activity.
- A restart mid-move aborts the move; no write is issued.

Tick counter:
- Counts 0..TICK_PERIOD-1, then wraps.
- tick pulses for one cycle when count==TICK_PERIOD-1.
- Counts only in RUN; holds its value in all other states.

Key FSM (turn requests):
- IDLE:
  - If exactly one key is low, latch pending turn (ccw: -1, cw: +1) and go to HOLD.
  - If both are low, latch nothing and go to HOLD.
- HOLD: go back to IDLE when both keys are high.
- At most one turn is pending. A further press before it is applied overwrites it. This prevents a 180-degree reversal within one tick.

Move FSM:
- RUN: on tick, apply the pending turn to dir (mod 4, wrapping 3->0 and 0->3) and clear it. Go to CHECK.
- CHECK:
  - Compute the target as pos plus CELL along dir, using 11-bit arithmetic so a move left or up from a small value is seen as negative.
  - If the target is outside [X_MIN..X_MAX]x[Y_MIN..Y_MAX], or negative: set game_over and go to DEAD.
  - Otherwise drive ram_addr = tx + ty*SCREEN_W and go to RDWAIT.
- RDWAIT: one cycle for RAM latency.
- DECIDE:
  - If ram_rdata != 0, set game_over and go to DEAD. Any nonzero value counts as a hit, including this player's own trail.
  - Otherwise go to WRITE.
- WRITE:
  - For one cycle: ram_wren=1, ram_addr=pos_x + pos_y*SCREEN_W (the cell being left), ram_wdata=TRAIL_CODE.
  - pos <= target. Return to RUN.
  - Total move latency from tick to position update: 4 cycles.
- DEAD: outputs frozen, ram_wren=0. Only reset or reiniciar exits.

Outputs:
- ram_wren is high only in WRITE.
- pixel_hit is combinational: pos_x <= next_x < pos_x+CELL and pos_y <= next_y < pos_y+CELL. It stays active while DEAD. It is 0 only while reset is high.
- game_over is registered and sticky.

Test Plan:
- Bounds crash:
  - Stimulus: TICK_PERIOD=4, start (216,240), heading right, no keys, RAM returning 0.
  - Required: pos_x steps 224, 232, ... every 8 cycles (tick period 4 plus 4-cycle move).
  - Each step has one ram_wren pulse at the old cell address, e.g. 216+240*640=153816.
  - The crash is detected when the target x exceeds 623 (x=624). game_over=1, pos_x stays 616.
- Single turn:
  - Stimulus: one cw press held over several ticks, then released.
  - Required: dir 0->1 exactly once. The next move has y=248, x unchanged.
  - Then ccw press: dir returns to 0.
- Both keys and overwrite:
  - Stimulus: both keys pressed together.
  - Required: no dir change.
  - Stimulus: ccw then cw, both before a tick.
  - Required: only cw applied, dir=1.
  - Stimulus: ccw pressed with dir=0.
  - Required: dir=3, wrapping through zero.
- Trail collision:
  - Stimulus: RAM model returns 8'h80 at address 232+240*640.
  - Required: after DECIDE, game_over=1 with no write that move. pos stays (224,240). The tick counter freezes.
- Restart:
  - Stimulus: pulse reiniciar mid-RDWAIT, and again in DEAD.
  - Required: next cycle pos=(216,240), dir=0, game_over=0, ram_wren=0, counter=0. Normal motion resumes.
- Render:
  - Stimulus: pos (216,240).
  - Required: pixel_hit=1 for next=(216,240) and (223,247); 0 for (224,240) and (216,248).

Source files
------------

// File: rtl/jogador_ctrl.sv
// Light-cycle player controller: keeps position/heading, advances one cell
// per movement tick, checks arena bounds and the shared trail RAM, and
// leaves its trail code behind. Drives a pixel-hit flag and sticky game_over.
module jogador_ctrl #(
  parameter int          START_X     = 216,
  parameter int          START_Y     = 240,
  parameter int          START_DIR   = 0,
  parameter int          CELL        = 8,
  parameter int          TICK_PERIOD = 1000000,
  parameter int          X_MIN       = 16,
  parameter int          X_MAX       = 623,
  parameter int          Y_MIN       = 16,
  parameter int          Y_MAX       = 463,
  parameter int          SCREEN_W    = 640,
  parameter int          ADDR_W      = 19,
  parameter logic [7:0]  TRAIL_CODE  = 8'hFF
) (
  input  logic              VGA_CLK,
  input  logic              reset,
  input  logic              reiniciar,
  input  logic              turn_ccw_n,
  input  logic              turn_cw_n,
  input  logic [9:0]        next_x,
  input  logic [9:0]        next_y,
  output logic              pixel_hit,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              game_over,
  output logic [1:0]        dir,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y
);

  localparam int CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_PERIOD - 1);
  localparam logic signed [10:0] STEP_S = 11'(CELL);
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic signed [10:0] YMIN_S = 11'(Y_MIN);
  localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);
  localparam logic [ADDR_W-1:0]  STRIDE = ADDR_W'(SCREEN_W);

  typedef enum logic [2:0] {S_RUN, S_CHECK, S_RDWAIT, S_DECIDE, S_WRITE, S_DEAD} move_t;
  typedef enum logic {K_IDLE, K_HOLD} key_t;

  move_t             state_q, state_d;
  key_t              key_q, key_d;
  logic              pend_v_q, pend_v_d;
  logic              pend_cw_q, pend_cw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        dir_q, dir_d;
  logic [9:0]        px_q, px_d, py_q, py_d;
  logic              go_q, go_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic signed [10:0] tx, ty;
  logic               oob;
  logic               tick;
  logic [ADDR_W-1:0]  tgt_addr, cur_addr;
  logic [10:0]        nx_u, ny_u, px_u, py_u;

  // Target cell from current position/heading (signed so left/up underflow is negative)
  always_comb begin
    tx = signed'({1'b0, px_q});
    ty = signed'({1'b0, py_q});
    case (dir_q)
      2'd0:    tx = signed'({1'b0, px_q}) + STEP_S;
      2'd1:    ty = signed'({1'b0, py_q}) + STEP_S;
      2'd2:    tx = signed'({1'b0, px_q}) - STEP_S;
      default: ty = signed'({1'b0, py_q}) - STEP_S;
    endcase
    oob = tx[10] || ty[10] || (tx < XMIN_S) || (tx > XMAX_S) ||
          (ty < YMIN_S) || (ty > YMAX_S);
    tgt_addr = ADDR_W'(tx[9:0]) + ADDR_W'(ty[9:0]) * STRIDE;
    cur_addr = ADDR_W'(px_q) + ADDR_W'(py_q) * STRIDE;
  end

  // Move FSM, tick counter and key FSM next-state logic
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    pend_v_d  = pend_v_q;
    pend_cw_d = pend_cw_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    px_d      = px_q;
    py_d      = py_q;
    go_d      = go_q;
    wren_d    = 1'b0;
    addr_d    = addr_q;
    tick      = (state_q == S_RUN) && (cnt_q == CNT_MAX);

    case (state_q)
      S_RUN: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          if (pend_v_q) dir_d = pend_cw_q ? dir_q + 2'd1 : dir_q - 2'd1;
          pend_v_d = 1'b0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (oob) begin
          go_d    = 1'b1;
          state_d = S_DEAD;
        end else begin
          addr_d  = tgt_addr;
          state_d = S_RDWAIT;
        end
      end
      S_RDWAIT: state_d = S_DECIDE;
      S_DECIDE: begin
        if (ram_rdata != 8'h00) begin
          go_d    = 1'b1;
          state_d = S_DEAD;
        end else begin
          wren_d  = 1'b1;
          addr_d  = cur_addr;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        px_d    = tx[9:0];
        py_d    = ty[9:0];
        state_d = S_RUN;
      end
      S_DEAD:  state_d = S_DEAD;
      default: state_d = S_RUN;
    endcase

    // Key latch evaluated after the tick clear so a same-cycle press is kept
    case (key_q)
      K_IDLE: begin
        if (!turn_ccw_n || !turn_cw_n) begin
          key_d = K_HOLD;
          if (turn_ccw_n != turn_cw_n) begin
            pend_v_d  = 1'b1;
            pend_cw_d = !turn_cw_n;
          end
        end
      end
      default: if (turn_ccw_n && turn_cw_n) key_d = K_IDLE;
    endcase
  end

  // State register with synchronous reset / restart
  always_ff @(posedge VGA_CLK) begin
    if (reset || reiniciar) begin
      state_q   <= S_RUN;
      key_q     <= K_IDLE;
      pend_v_q  <= 1'b0;
      pend_cw_q <= 1'b0;
      cnt_q     <= '0;
      dir_q     <= 2'(START_DIR);
      px_q      <= 10'(START_X);
      py_q      <= 10'(START_Y);
      go_q      <= 1'b0;
      wren_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      pend_v_q  <= pend_v_d;
      pend_cw_q <= pend_cw_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      px_q      <= px_d;
      py_q      <= py_d;
      go_q      <= go_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
    end
  end

  // Player square hit test for the compositor
  always_comb begin
    nx_u = {1'b0, next_x};
    ny_u = {1'b0, next_y};
    px_u = {1'b0, px_q};
    py_u = {1'b0, py_q};
    pixel_hit = !reset &&
                (nx_u >= px_u) && (nx_u < px_u + 11'(CELL)) &&
                (ny_u >= py_u) && (ny_u < py_u + 11'(CELL));
  end

  assign ram_addr  = addr_q;
  assign ram_wren  = wren_q;
  assign ram_wdata = TRAIL_CODE;
  assign game_over = go_q;
  assign dir       = dir_q;
  assign pos_x     = px_q;
  assign pos_y     = py_q;

endmodule
